simple_fifo_downsizer: RTL and testbench
========================================

# simple_fifo_downsizer

Width-converting FIFO: accepts wide words on the write side and delivers them as narrow slices on the read side, least-significant slice first. It is the wide-to-narrow counterpart of the narrow-to-wide FIFO adapter. It sits between wide datapaths, such as DMA or bus beats, and narrow consumers, such as serializers or byte engines. Frame boundaries are carried through a `last` flag.

## Interface
Parameters:
- DATA_IN_WIDTH, 128: write word width. Must be an integer multiple R = DATA_IN_WIDTH/DATA_OUT_WIDTH, with R a power of two and R ≥ 1.
- DATA_OUT_WIDTH, 16: read slice width.
- ADDR_WIDTH, 4: storage depth DEPTH = 2^ADDR_WIDTH wide entries.
- FULL_SLACK, 1: wr_full asserts when the count is ≥ DEPTH − FULL_SLACK. Range is 0..DEPTH−1.
- USE_LAST, 1: when 1, wr_last is stored and rd_last is generated. When 0, rd_last is tied to 0.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- wr_ena, input, 1: write strobe, one wide word per cycle.
- wr_dat, input, DATA_IN_WIDTH: write data.
- wr_last, input, 1: marks the final wide word of a frame.
- wr_full, output, 1: almost-full indicator, per FULL_SLACK.
- rd_ena, input, 1: read strobe, one narrow slice per cycle.
- rd_dat, output, DATA_OUT_WIDTH: registered read data.
- rd_last, output, 1: high with the final slice of a wr_last word.
- rd_empty, output, 1: no unread wide entry.
- rd_dat_cnt, output, ADDR_WIDTH+1: number of wide entries held. A partially read entry counts as held.

## Operation
- Storage is DEPTH entries, each holding {last, DATA_IN_WIDTH data}.
  - Write pointer and read pointer are ADDR_WIDTH bits each and wrap modulo DEPTH.
  - Slice index sidx is log2(R) bits and selects rd slice sidx, i.e. bits [sidx*DATA_OUT_WIDTH +: DATA_OUT_WIDTH].
- Write accepted = wr_ena && (cnt != DEPTH).
  - Stores {wr_last, wr_dat} at wptr, then wptr+1.
  - A write when cnt == DEPTH is silently dropped. This holds even if a read frees an entry in the same cycle.
  - wr_full is only advisory when FULL_SLACK > 0; writes still succeed until cnt == DEPTH.
- Read accepted = rd_ena && !rd_empty.
  - On the accepting edge, rd_dat is loaded with slice sidx of mem[rptr].
  - rd_last is loaded with (USE_LAST && mem[rptr].last && sidx == R−1).
  - sidx then increments.
  - When sidx == R−1, sidx wraps to 0, rptr increments and the entry is freed.
  - With R == 1, every read frees an entry.
- rd_ena while empty is ignored: rd_dat, rd_last and all pointers hold.
- When no read is accepted, rd_dat and rd_last hold their last values. They are not cleared.
- Count update per cycle: cnt_next = cnt + wr_accept − free, where free = read accepted && sidx == R−1. Simultaneous write and free leaves cnt unchanged.
- Outputs derived from cnt:
  - rd_empty = (cnt == 0).
  - wr_full = (cnt ≥ DEPTH − FULL_SLACK).
  - rd_dat_cnt = cnt.
  - All three are registered or derived from registered cnt, with no combinational path from inputs.
- Reset asserted at any time, including mid-frame or with a partial slice consumed:
  - wptr = rptr = sidx = cnt = 0.
  - All held data is discarded; memory contents need not be cleared.

## Timing
- Reset values: rd_dat = 0, rd_last = 0, rd_empty = 1, wr_full = 0 (or 1 if FULL_SLACK ≥ DEPTH, which is illegal), rd_dat_cnt = 0.
- Write→read latency: a word written at edge N deasserts rd_empty after edge N. Its first slice can be read at edge N+1 and appears on rd_dat after N+1.
- Read latency: rd_dat and rd_last are valid immediately after the accepting edge, i.e. one register stage.
- Full status: wr_full and rd_dat_cnt reflect all writes and frees up to the previous edge.
- Throughput: continuous reads deliver one slice per cycle. Sustained throughput needs one write per R cycles.

## Test plan
- Reset: assert rst asynchronously between edges.
  - Outputs immediately show rd_empty = 1, rd_dat_cnt = 0, wr_full = 0, rd_dat = 0, rd_last = 0.
  - rd_ena while empty leaves rd_dat = 0.
- Ordering (R = 8):
  - Write W0 = 0x0007_0006_0005_0004_0003_0002_0001_0000, then W1 = W0 + 0x0008_0008_..._0008.
  - 16 reads return 0x0000..0x000F in order.
  - rd_dat_cnt steps 2→1 after the 8th read and 1→0 after the 16th; rd_empty rises after the 16th.
- Full/slack (DEPTH = 16, FULL_SLACK = 1):
  - After 15 writes, wr_full = 1 and cnt = 15. The 16th write is accepted (cnt = 16); the 17th is dropped.
  - 128 reads return exactly the 16 stored words.
- Last:
  - Write 3 words with wr_last = 1 on the 3rd only.
  - rd_last is high only on read 24; it is low on reads 8 and 16.
- Concurrent stream:
  - Prefill 2 words. Then for 64 cycles hold rd_ena = 1 and write one incrementing word every 8th cycle.
  - No slice is lost or duplicated, cnt stays within 1..2, and rd_empty is never asserted.
- Mid-operation reset:
  - Write 4 words and read 3 slices, then pulse rst.
  - Afterwards rd_empty = 1 and cnt = 0. A new write followed by reads returns that word's slices starting at slice 0.

Source files
------------

// File: rtl/simple_fifo_downsizer.sv
// simple_fifo_downsizer: wide-write / narrow-read FIFO.
// Wide entries are read out as slices, least-significant slice first.
module simple_fifo_downsizer #(
   parameter int DATA_IN_WIDTH  = 128,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int ADDR_WIDTH     = 4,
   parameter int FULL_SLACK     = 1,
   parameter int USE_LAST       = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_ena,
   input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
   input  logic                      wr_last,
   output logic                      wr_full,
   input  logic                      rd_ena,
   output logic [DATA_OUT_WIDTH-1:0] rd_dat,
   output logic                      rd_last,
   output logic                      rd_empty,
   output logic [ADDR_WIDTH:0]       rd_dat_cnt
);

   localparam int R     = DATA_IN_WIDTH / DATA_OUT_WIDTH;
   localparam int SW    = (R > 1) ? $clog2(R) : 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0] CNT_MAX   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] FULL_TH   = (ADDR_WIDTH + 1)'(DEPTH - FULL_SLACK);
   localparam logic [SW-1:0]       SIDX_LAST = SW'(R - 1);

   // Each entry is {last, data}.
   logic [DATA_IN_WIDTH:0]  mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   wptr;
   logic [ADDR_WIDTH-1:0]   rptr;
   logic [SW-1:0]           sidx;
   logic [ADDR_WIDTH:0]     cnt;

   logic                    wr_accept;
   logic                    rd_accept;
   logic                    last_slice;
   logic                    free;
   logic [DATA_IN_WIDTH:0]  rd_word;
   logic [DATA_OUT_WIDTH-1:0] slice;

   // With R == 1, SIDX_LAST is 0 and sidx never leaves 0, so
   // every read is the final slice and frees its entry.
   assign wr_accept  = wr_ena && (cnt != CNT_MAX);
   assign rd_accept  = rd_ena && !rd_empty;
   assign last_slice = (sidx == SIDX_LAST);
   assign free       = rd_accept && last_slice;

   assign rd_word = mem[rptr];
   assign slice   = rd_word[int'(sidx) * DATA_OUT_WIDTH +: DATA_OUT_WIDTH];

   // Status flags come straight from the registered count.
   assign rd_empty   = (cnt == '0);
   assign wr_full    = (cnt >= FULL_TH);
   assign rd_dat_cnt = cnt;

   // Storage array; deliberately not reset, contents are don't-care.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wptr] <= {wr_last, wr_dat};
      end
   end

   // Write pointer advance on accepted writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
      end else if (wr_accept) begin
         wptr <= wptr + 1'b1;
      end
   end

   // Slice walk within the head entry; pop the entry on its last slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sidx <= '0;
         rptr <= '0;
      end else if (rd_accept) begin
         if (last_slice) begin
            sidx <= '0;
            rptr <= rptr + 1'b1;
         end else begin
            sidx <= sidx + 1'b1;
         end
      end
   end

   // Registered read data; holds its value when no read is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_dat  <= '0;
         rd_last <= 1'b0;
      end else if (rd_accept) begin
         rd_dat  <= slice;
         rd_last <= (USE_LAST != 0) && rd_word[DATA_IN_WIDTH] && last_slice;
      end
   end

   // Occupancy in wide entries; a partly read entry still counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (wr_accept && !free) begin
         cnt <= cnt + 1'b1;
      end else if (free && !wr_accept) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_simple_fifo_downsizer.sv
// tb_simple_fifo_downsizer: directed self-checking bench.
// Default parameters: R = 8, DEPTH = 16, FULL_SLACK = 1.
module tb_simple_fifo_downsizer;

   logic         clk;
   logic         rst;
   logic         wr_ena;
   logic [127:0] wr_dat;
   logic         wr_last;
   logic         wr_full;
   logic         rd_ena;
   logic [15:0]  rd_dat;
   logic         rd_last;
   logic         rd_empty;
   logic [4:0]   rd_dat_cnt;

   int checks = 0;
   int errors = 0;

   simple_fifo_downsizer dut (
      .clk        (clk),
      .rst        (rst),
      .wr_ena     (wr_ena),
      .wr_dat     (wr_dat),
      .wr_last    (wr_last),
      .wr_full    (wr_full),
      .rd_ena     (rd_ena),
      .rd_dat     (rd_dat),
      .rd_last    (rd_last),
      .rd_empty   (rd_empty),
      .rd_dat_cnt (rd_dat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wide word whose slice k holds base + k.
   function automatic logic [127:0] mk(input int base);
      logic [127:0] w;
      w = '0;
      for (int k = 0; k < 8; k++) begin
         w[k*16 +: 16] = 16'(base + k);
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int base, input logic last);
      wr_ena  = 1'b1;
      wr_dat  = mk(base);
      wr_last = last;
      tick();
      wr_ena  = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic rd;
      rd_ena = 1'b1;
      tick();
      rd_ena = 1'b0;
   endtask

   initial begin
      rst     = 1'b0;
      wr_ena  = 1'b0;
      wr_dat  = '0;
      wr_last = 1'b0;
      rd_ena  = 1'b0;

      // Asynchronous reset between edges.
      #3 rst = 1'b1;
      #1;
      chk("rst_empty", rd_empty, 1);
      chk("rst_cnt", rd_dat_cnt, 0);
      chk("rst_full", wr_full, 0);
      chk("rst_dat", rd_dat, 0);
      chk("rst_last", rd_last, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      rd();
      chk("empty_rd_dat", rd_dat, 0);
      chk("empty_rd_empty", rd_empty, 1);
      chk("empty_rd_cnt", rd_dat_cnt, 0);

      // Ordering.
      wr(0, 1'b0);
      chk("ord_empty_w0", rd_empty, 0);
      chk("ord_cnt_w0", rd_dat_cnt, 1);
      wr(8, 1'b0);
      chk("ord_cnt_w1", rd_dat_cnt, 2);
      for (int i = 0; i < 16; i++) begin
         rd();
         chk($sformatf("ord_dat%0d", i), rd_dat, 128'(i));
         if (i == 6)  chk("ord_cnt7", rd_dat_cnt, 2);
         if (i == 7)  chk("ord_cnt8", rd_dat_cnt, 1);
         if (i == 14) chk("ord_empty15", rd_empty, 0);
         if (i == 15) chk("ord_cnt16", rd_dat_cnt, 0);
         if (i == 15) chk("ord_empty16", rd_empty, 1);
      end

      // Full and slack.
      for (int w = 0; w < 15; w++) begin
         wr(w * 8, 1'b0);
         if (w == 13) chk("full_14", wr_full, 0);
      end
      chk("full_15", wr_full, 1);
      chk("cnt_15", rd_dat_cnt, 15);
      wr(15 * 8, 1'b0);
      chk("cnt_16", rd_dat_cnt, 16);
      chk("full_16", wr_full, 1);
      wr(16'hff00, 1'b0);
      chk("cnt_17_dropped", rd_dat_cnt, 16);
      for (int i = 0; i < 128; i++) begin
         rd();
         chk($sformatf("full_dat%0d", i), rd_dat, 128'(i));
      end
      chk("full_drain_empty", rd_empty, 1);
      chk("full_drain_full", wr_full, 0);
      rd();
      chk("full_extra_hold", rd_dat, 127);

      // Frame last flag.
      wr(16'h0300, 1'b0);
      wr(16'h0308, 1'b0);
      wr(16'h0310, 1'b1);
      for (int i = 0; i < 24; i++) begin
         rd();
         chk($sformatf("last_dat%0d", i), rd_dat, 128'(16'h0300 + i));
         chk($sformatf("last_flag%0d", i + 1), rd_last, 128'(i == 23));
      end
      tick();
      chk("last_hold", rd_last, 1);

      // Concurrent stream: writes coincide with frees.
      wr(16'h0100, 1'b0);
      wr(16'h0108, 1'b0);
      for (int c = 0; c < 64; c++) begin
         rd_ena = 1'b1;
         if (c % 8 == 7) begin
            wr_ena = 1'b1;
            wr_dat = mk(16'h0110 + (c / 8) * 8);
         end
         tick();
         wr_ena = 1'b0;
         chk($sformatf("str_dat%0d", c), rd_dat, 128'(16'h0100 + c));
         chk($sformatf("str_empty%0d", c), rd_empty, 0);
         chk($sformatf("str_cnt%0d", c), rd_dat_cnt, 128'((c % 8 == 7) ? 2 : 2));
      end
      rd_ena = 1'b0;
      for (int c = 64; c < 80; c++) begin
         rd();
         chk($sformatf("str_tail%0d", c), rd_dat, 128'(16'h0100 + c));
      end
      chk("str_final_empty", rd_empty, 1);

      // Mid-operation reset.
      for (int w = 0; w < 4; w++) wr(16'h0400 + w * 8, 1'b0);
      for (int i = 0; i < 3; i++) rd();
      chk("mid_pre_dat", rd_dat, 16'h0402);
      chk("mid_pre_cnt", rd_dat_cnt, 4);
      #2 rst = 1'b1;
      #1;
      chk("mid_empty", rd_empty, 1);
      chk("mid_cnt", rd_dat_cnt, 0);
      chk("mid_dat", rd_dat, 0);
      #1 rst = 1'b0;
      tick();
      chk("mid_after_empty", rd_empty, 1);
      wr(16'h0500, 1'b0);
      chk("mid_new_cnt", rd_dat_cnt, 1);
      for (int i = 0; i < 8; i++) begin
         rd();
         chk($sformatf("mid_new_dat%0d", i), rd_dat, 128'(16'h0500 + i));
      end
      chk("mid_new_empty", rd_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
